// File: rtl/ic_pingpong_ctrl_pkg.sv
// rtl/ic_pingpong_ctrl_pkg.sv - shared bank-state encoding and size defaults
package ic_pingpong_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int CNT_W_DEF  = 5;

  typedef enum logic [3:0] {
    BK_FREE     = 4'b0001,
    BK_FILLING  = 4'b0010,
    BK_READY    = 4'b0100,
    BK_DRAINING = 4'b1000
  } bank_state_e;

  function automatic logic can_write(input bank_state_e s);
    return (s == BK_FREE) || (s == BK_FILLING);
  endfunction

  function automatic logic can_read(input bank_state_e s);
    return (s == BK_READY) || (s == BK_DRAINING);
  endfunction

endpackage

// File: rtl/ic_bank_tracker.sv
// rtl/ic_bank_tracker.sv - lifecycle state and burst length of one ping-pong bank
module ic_bank_tracker
  import ic_pingpong_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_start,
  input  logic             wr_close,
  input  logic             rd_start,
  input  logic             rd_done,
  input  logic [CNT_W-1:0] len_in,
  output bank_state_e      state_q,
  output bank_state_e      state_d,
  output logic [CNT_W-1:0] len_q,
  output logic [CNT_W-1:0] len_d
);

  // A single-word burst may close straight from FREE, and a len=1 bank
  // may finish draining straight from READY.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      BK_FREE: begin
        if (wr_close) begin
          state_d = BK_READY;
          len_d   = len_in;
        end else if (wr_start) begin
          state_d = BK_FILLING;
        end
      end
      BK_FILLING: begin
        if (wr_close) begin
          state_d = BK_READY;
          len_d   = len_in;
        end
      end
      BK_READY: begin
        if (rd_done) state_d = BK_FREE;
        else if (rd_start) state_d = BK_DRAINING;
      end
      BK_DRAINING: begin
        if (rd_done) state_d = BK_FREE;
      end
      default: state_d = BK_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BK_FREE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/ic_pingpong_ctrl.sv
// rtl/ic_pingpong_ctrl.sv - ping-pong bank scheduler between DDR unpacker and SA column
module ic_pingpong_ctrl
  import ic_pingpong_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              wlast,
  output logic              wrdy,
  input  logic              rd_en_pre,
  output logic              rd_en_nxt,
  output logic              rrdy,
  output logic [1:0]        bank_wr_en,
  output logic [DATA_W-1:0] bank_din,
  output logic [1:0]        bank_rd_en,
  input  logic [DATA_W-1:0] bank_dout0,
  input  logic [DATA_W-1:0] bank_dout1,
  input  logic [1:0]        bank_full,
  input  logic [1:0]        bank_empty,
  output logic [DATA_W-1:0] col_data_in,
  output logic              col_valid_in,
  output logic              empty,
  output logic              err
);

  logic             wsel_q, wsel_d, rsel_q, rsel_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, rcnt_inc;
  logic             wrdy_q, wrdy_d, rrdy_q, rrdy_d;
  logic             wr_acc, wr_close, rd_acc, rd_done;
  logic [1:0]       bank_wr_en_q, bank_wr_en_d, bank_rd_en_q, bank_rd_en_d;
  logic [DATA_W-1:0] bank_din_q, bank_din_d, col_data_q, col_data_d;
  logic             rd_en_nxt_q, rsel1_q, rsel1_d, v2_q, v2_d, sel2_q, sel2_d;
  logic             col_valid_q, col_valid_d, err_q, err_d;
  bank_state_e      st_q [2];
  bank_state_e      st_d [2];
  logic [CNT_W-1:0] len_q [2];
  logic [CNT_W-1:0] len_d [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    ic_bank_tracker #(.CNT_W(CNT_W)) u_trk (
      .clk      (clk),
      .rst      (rst),
      .wr_start (wr_acc && (wsel_q == 1'(g))),
      .wr_close (wr_close && (wsel_q == 1'(g))),
      .rd_start (rd_acc && (rsel_q == 1'(g))),
      .rd_done  (rd_done && (rsel_q == 1'(g))),
      .len_in   (wcnt_q + CNT_W'(1)),
      .state_q  (st_q[g]),
      .state_d  (st_d[g]),
      .len_q    (len_q[g]),
      .len_d    (len_d[g])
    );
  end

  always_comb begin
    wr_acc   = wr_en && wrdy_q;
    wr_close = wr_acc && (wlast || (wcnt_q == CNT_W'(DEPTH - 1)));
    rd_acc   = rd_en_pre && rrdy_q;
    rcnt_inc = rcnt_q + CNT_W'(1);
    rd_done  = rd_acc && (rcnt_inc == len_q[rsel_q]);

    wsel_d = wsel_q ^ wr_close;
    rsel_d = rsel_q ^ rd_done;
    wcnt_d = wr_close ? '0 : (wr_acc ? wcnt_q + CNT_W'(1) : wcnt_q);
    rcnt_d = rd_done ? '0 : (rd_acc ? rcnt_inc : rcnt_q);

    // Ready flags look at next-cycle bank state so a bank freed this cycle
    // is usable immediately; a closing write always costs one idle cycle.
    wrdy_d = !wr_close && can_write(st_d[wsel_d]);
    rrdy_d = can_read(st_d[rsel_d]) && (rcnt_d < len_d[rsel_d]);

    bank_wr_en_d = wr_acc ? (wsel_q ? 2'b10 : 2'b01) : 2'b00;
    bank_din_d   = wr_acc ? din : '0;
    bank_rd_en_d = rd_acc ? (rsel_q ? 2'b10 : 2'b01) : 2'b00;

    rsel1_d     = rsel_q;
    v2_d        = |bank_rd_en_q;
    sel2_d      = rsel1_q;
    col_valid_d = v2_q;
    col_data_d  = v2_q ? (sel2_q ? bank_dout1 : bank_dout0) : '0;

    err_d = err_q
          || (wr_acc && (st_q[wsel_q] == BK_FILLING) && bank_full[wsel_q])
          || (|(bank_rd_en_q & bank_empty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_q       <= 1'b0;
      rsel_q       <= 1'b0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      wrdy_q       <= 1'b0;
      rrdy_q       <= 1'b0;
      bank_wr_en_q <= '0;
      bank_din_q   <= '0;
      bank_rd_en_q <= '0;
      rd_en_nxt_q  <= 1'b0;
      rsel1_q      <= 1'b0;
      v2_q         <= 1'b0;
      sel2_q       <= 1'b0;
      col_valid_q  <= 1'b0;
      col_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      wsel_q       <= wsel_d;
      rsel_q       <= rsel_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      wrdy_q       <= wrdy_d;
      rrdy_q       <= rrdy_d;
      bank_wr_en_q <= bank_wr_en_d;
      bank_din_q   <= bank_din_d;
      bank_rd_en_q <= bank_rd_en_d;
      rd_en_nxt_q  <= rd_en_pre;
      rsel1_q      <= rsel1_d;
      v2_q         <= v2_d;
      sel2_q       <= sel2_d;
      col_valid_q  <= col_valid_d;
      col_data_q   <= col_data_d;
      err_q        <= err_d;
    end
  end

  assign wrdy         = wrdy_q;
  assign rrdy         = rrdy_q;
  assign rd_en_nxt    = rd_en_nxt_q;
  assign bank_wr_en   = bank_wr_en_q;
  assign bank_din     = bank_din_q;
  assign bank_rd_en   = bank_rd_en_q;
  assign col_valid_in = col_valid_q;
  assign col_data_in  = col_data_q;
  assign err          = err_q;
  assign empty        = (st_q[0] == BK_FREE) && (st_q[1] == BK_FREE);

endmodule

// File: tb/tb_ic_pingpong_ctrl.sv
// tb/tb_ic_pingpong_ctrl.sv - directed self-checking bench for ic_pingpong_ctrl
module tb_ic_pingpong_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst;
  logic [DATA_W-1:0] din;
  logic wr_en, wlast, wrdy, rd_en_pre, rd_en_nxt, rrdy;
  logic [1:0] bank_wr_en, bank_rd_en, bank_full, bank_empty;
  logic [DATA_W-1:0] bank_din, bank_dout0, bank_dout1, col_data_in;
  logic col_valid_in, empty, err;
  logic force_empty0;

  always #5 clk = ~clk;

  ic_pingpong_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .wlast(wlast), .wrdy(wrdy),
    .rd_en_pre(rd_en_pre), .rd_en_nxt(rd_en_nxt), .rrdy(rrdy),
    .bank_wr_en(bank_wr_en), .bank_din(bank_din), .bank_rd_en(bank_rd_en),
    .bank_dout0(bank_dout0), .bank_dout1(bank_dout1),
    .bank_full(bank_full), .bank_empty(bank_empty),
    .col_data_in(col_data_in), .col_valid_in(col_valid_in), .empty(empty), .err(err)
  );

  // Two FIFO bank models with 1-cycle read latency
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [DATA_W-1:0] fdout [2];
  int fcnt [2];
  int fwp [2];
  int frp [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        fcnt[i] <= 0;
        fwp[i]  <= 0;
        frp[i]  <= 0;
        fdout[i] <= '0;
      end else begin
        if (bank_wr_en[i]) begin
          mem[i][fwp[i]] <= bank_din;
          fwp[i] <= (fwp[i] + 1) % DEPTH;
        end
        if (bank_rd_en[i]) begin
          fdout[i] <= mem[i][frp[i]];
          frp[i] <= (frp[i] + 1) % DEPTH;
        end
        fcnt[i] <= fcnt[i] + (bank_wr_en[i] ? 1 : 0) - (bank_rd_en[i] ? 1 : 0);
      end
    end
  end

  assign bank_dout0    = fdout[0];
  assign bank_dout1    = fdout[1];
  assign bank_full[0]  = (fcnt[0] == DEPTH);
  assign bank_full[1]  = (fcnt[1] == DEPTH);
  assign bank_empty[0] = (fcnt[0] == 0) || force_empty0;
  assign bank_empty[1] = (fcnt[1] == 0);

  logic [DATA_W-1:0] col_q [$];
  always @(negedge clk) begin
    if (!rst && col_valid_in) col_q.push_back(col_data_in);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int base, input int n, input bit use_wlast);
    int guard;
    for (int k = 0; k < n; k++) begin
      wr_en = 1'b0;
      wlast = 1'b0;
      guard = 0;
      while (!wrdy && guard < 50) begin
        step();
        guard++;
      end
      chk("ww_bound", 32'(guard < 50), 32'd1);
      wr_en = 1'b1;
      din   = DATA_W'(base + k);
      wlast = use_wlast && (k == n - 1);
      step();
    end
    wr_en = 1'b0;
    wlast = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, gaps, guard;
    logic [4:0] pat;
    rst = 1'b1; din = '0; wr_en = 1'b0; wlast = 1'b0; rd_en_pre = 1'b0; force_empty0 = 1'b0;

    // 1. reset
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_wrdy", 32'(wrdy), 32'd0);
    chk("rst_rrdy", 32'(rrdy), 32'd0);
    chk("rst_wr_en", 32'(bank_wr_en), 32'd0);
    chk("rst_rd_en", 32'(bank_rd_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_colv", 32'(col_valid_in), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_wrdy", 32'(wrdy), 32'd1);

    // 2. full 16-word burst into bank0
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = DATA_W'(i + 1);
      step();
      chk("t2_bank_wr_en", 32'(bank_wr_en), 32'd1);
      chk("t2_bank_din", 32'(bank_din), 32'(i + 1));
      chk("t2_wrdy", 32'(wrdy), 32'(i < 15));
    end
    wr_en = 1'b0;
    chk("t2_rrdy", 32'(rrdy), 32'd1);
    chk("t2_not_empty", 32'(empty), 32'd0);
    step();
    chk("t2_wrdy_back", 32'(wrdy), 32'd1);
    chk("t2_wr_idle", 32'(bank_wr_en), 32'd0);
    chk("t2_fifo0_cnt", 32'(fcnt[0]), 32'd16);

    col_q.delete();
    rd_en_pre = 1'b1;
    repeat (16) step();
    rd_en_pre = 1'b0;
    chk("t2_rrdy_drained", 32'(rrdy), 32'd0);
    repeat (4) step();
    chk("t2_col_count", 32'(col_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < col_q.size(); i++)
      chk("t2_col_data", 32'(col_q[i]), 32'(i + 1));
    chk("t2_empty", 32'(empty), 32'd1);

    // 3. short burst with wlast into bank1, drain with 8 strobes
    write_words(8'hA1, 5, 1'b1);
    chk("t3_wrdy_close", 32'(wrdy), 32'd0);
    chk("t3_rrdy", 32'(rrdy), 32'd1);
    for (int j = 0; j < 11; j++) begin
      rd_en_pre = (j < 8);
      step();
      chk("t3_rd_en_nxt", 32'(rd_en_nxt), 32'(j < 8));
      chk("t3_bank_rd_en", 32'(bank_rd_en), (j < 5) ? 32'd2 : 32'd0);
      chk("t3_col_valid", 32'(col_valid_in), 32'(j >= 2 && j <= 6));
      chk("t3_col_data", 32'(col_data_in), (j >= 2 && j <= 6) ? 32'(8'hA1 + j - 2) : 32'd0);
    end
    chk("t3_rrdy_end", 32'(rrdy), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_wrdy", 32'(wrdy), 32'd1);

    // 4. ping-pong: 48 words streamed while reading continuously
    col_q.delete();
    rd_en_pre = 1'b1;
    acc = 0; gaps = 0; guard = 0;
    while (acc < 48 && guard < 200) begin
      wr_en = 1'b1;
      wlast = 1'b0;
      din   = DATA_W'(100 + acc);
      if (wrdy) acc++;
      else gaps++;
      step();
      guard++;
    end
    wr_en = 1'b0;
    chk("t4_bound", 32'(guard < 200), 32'd1);
    chk("t4_gaps", 32'(gaps), 32'd2);
    repeat (60) step();
    rd_en_pre = 1'b0;
    chk("t4_col_count", 32'(col_q.size()), 32'd48);
    for (int i = 0; i < 48 && i < col_q.size(); i++)
      chk("t4_col_data", 32'(col_q[i]), 32'(100 + i));
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);

    // 5. backpressure
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("t5_wrdy", 32'(wrdy), 32'd1);
    pat = 5'b01101;
    for (int j = 0; j < 5; j++) begin
      rd_en_pre = pat[j];
      step();
      chk("t5_rd_en_nxt", 32'(rd_en_nxt), 32'(pat[j]));
      chk("t5_no_rd", 32'(bank_rd_en), 32'd0);
    end
    rd_en_pre = 1'b0;
    write_words(8'h10, 4, 1'b1);
    write_words(8'h20, 4, 1'b1);
    wr_en = 1'b1;
    din   = 8'hEE;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t5_wrdy_low", 32'(wrdy), 32'd0);
      chk("t5_no_wr", 32'(bank_wr_en), 32'd0);
    end
    wr_en = 1'b0;
    chk("t5_rrdy", 32'(rrdy), 32'd1);
    chk("t5_not_empty", 32'(empty), 32'd0);

    // 6. forced empty during drain, then reset mid-drain
    rd_en_pre = 1'b1;
    step();
    chk("t6_rd_bank0", 32'(bank_rd_en), 32'd1);
    force_empty0 = 1'b1;
    chk("t6_err_before", 32'(err), 32'd0);
    step();
    chk("t6_err_set", 32'(err), 32'd1);
    force_empty0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t6_err_sticky", 32'(err), 32'd1);
    end
    rst = 1'b1;
    step();
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_colv", 32'(col_valid_in), 32'd0);
    chk("t6_rst_rd_en", 32'(bank_rd_en), 32'd0);
    chk("t6_rst_rrdy", 32'(rrdy), 32'd0);
    rst = 1'b0;
    rd_en_pre = 1'b0;
    step();
    step();
    chk("t6_colv_after", 32'(col_valid_in), 32'd0);
    chk("t6_wrdy_after", 32'(wrdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
